// File: rtl/ml555_cfg_pkg.sv
// rtl/ml555_cfg_pkg.sv - shared types, constants and helpers for the ML555 configuration sequencer
package ml555_cfg_pkg;

  typedef enum logic [2:0] {
    ST_CLK_MR     = 3'd0,
    ST_PROG       = 3'd1,
    ST_WAIT_INIT  = 3'd2,
    ST_LOAD       = 3'd3,
    ST_CONFIGURED = 3'd4,
    ST_FAILED     = 3'd5
  } cfg_state_e;

  localparam logic [2:0] ICS_FSEL_100M = 3'b100;
  localparam logic [2:0] ICS_FSEL_125M = 3'b010;
  localparam logic [2:0] ICS_FSEL_250M = 3'b000;

  // Smallest r with 2**r >= value; used to size counters as clog2(limit+1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ml555_debounce.sv
// rtl/ml555_debounce.sv - pushbutton synchroniser and debouncer with falling-edge pulse
module ml555_debounce
  import ml555_cfg_pkg::*;
#(
  parameter int CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic fall_o
);

  localparam int CW = (clog2(CYCLES + 1) > 0) ? clog2(CYCLES + 1) : 1;

  logic [1:0]    sync_q;
  logic          level_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;

  // Synchronise the raw input, then only move the level after CYCLES stable differing samples.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= CW'(CYCLES - 1)) begin
        level_q <= sync_q[1];
        fall_q  <= ~sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ml555_cfg_sequencer.sv
// rtl/ml555_cfg_sequencer.sv - ML555 Platform Flash SelectMAP configuration sequencer
module ml555_cfg_sequencer
  import ml555_cfg_pkg::*;
#(
  parameter int         NUM_FLASH         = 2,
  parameter int         REV_W             = 1,
  parameter int         FLASH_W           = 1,
  parameter int         DEBOUNCE_CYCLES   = 16,
  parameter int         PROG_PULSE_CYCLES = 8,
  parameter int         MR_CYCLES         = 4,
  parameter int         DONE_TIMEOUT      = 1024,
  parameter int         MAX_RETRIES       = 2,
  parameter int         FALLBACK_IMAGE    = 0,
  parameter logic [2:0] ICS_FSEL_DEFAULT  = 3'b010,
  localparam int        IMG_W             = FLASH_W + REV_W
) (
  input  logic                 CLK,
  input  logic                 RST_B,
  input  logic [IMG_W-1:0]     IMAGE_SEL,
  input  logic                 MAN_AUTO,
  input  logic                 PROG_SW_B,
  input  logic                 INIT_B,
  input  logic                 FPGA_DONE,
  input  logic                 FPGA_BUSY_B,
  input  logic [2:0]           ICS_FSEL_REQ,
  output logic                 PROG_B,
  output logic                 FLASH_CF_B,
  output logic [REV_W-1:0]     FLASH_SEL,
  output logic [NUM_FLASH-1:0] FLASH_CE_B,
  output logic                 FLASH_OE_RESET_B,
  output logic                 BUSY_TO_FLASH_B,
  output logic                 FPGA_CS_B,
  output logic                 FPGA_RDWR_B,
  output logic [2:0]           ICS_FSEL,
  output logic                 ICS_MR,
  output logic                 ICS_OEA,
  output logic [2:0]           CFG_STATE,
  output logic                 CFG_ERROR,
  output logic [IMG_W-1:0]     ACTIVE_IMAGE
);

  // One shared phase timer, wide enough for the longest of the three timed phases.
  localparam int TMAX_A = (PROG_PULSE_CYCLES > MR_CYCLES) ? PROG_PULSE_CYCLES : MR_CYCLES;
  localparam int TMAX   = (DONE_TIMEOUT > TMAX_A) ? DONE_TIMEOUT : TMAX_A;
  localparam int TW     = clog2(TMAX + 1);
  localparam int RW     = (clog2(MAX_RETRIES + 1) > 0) ? clog2(MAX_RETRIES + 1) : 1;

  cfg_state_e     state_q, state_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic [IMG_W-1:0] img_q, img_d;
  logic [2:0]     fsel_q, fsel_d;
  logic           err_q, err_d;
  logic           done_prev_q;

  logic           btn_level;
  logic           btn_fall;
  logic           btn_press;
  logic           load_fail;
  logic           ce_en;
  logic [IMG_W-1:0] sel_img;

  ml555_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i   (CLK),
    .rst_ni  (RST_B),
    .raw_i   (PROG_SW_B),
    .level_o (btn_level),
    .fall_o  (btn_fall)
  );

  // The pulse and the freshly-low level arrive together; requiring both rejects a stray pulse.
  assign btn_press = btn_fall & ~btn_level;
  assign load_fail = ~INIT_B | (cnt_q >= TW'(DONE_TIMEOUT - 1));

  // Image to latch from the jumpers; MAN_AUTO pins the revision field to zero.
  always_comb begin
    sel_img = IMAGE_SEL;
    if (MAN_AUTO) sel_img[REV_W-1:0] = '0;
  end

  // Sequencer next-state: phase timing, retry/fallback decisions, button and clock-change overrides.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '1) ? cnt_q + TW'(1) : cnt_q;
    retry_d = retry_q;
    img_d   = img_q;
    fsel_d  = fsel_q;
    err_d   = err_q;

    unique case (state_q)
      ST_CLK_MR: begin
        if (cnt_q >= TW'(MR_CYCLES - 1)) begin
          state_d = ST_PROG;
          cnt_d   = '0;
          img_d   = sel_img;
          retry_d = '0;
        end
      end
      ST_PROG: begin
        if (cnt_q >= TW'(PROG_PULSE_CYCLES - 1)) begin
          state_d = ST_WAIT_INIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT_INIT: begin
        if (INIT_B) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (FPGA_DONE) begin
          state_d = ST_CONFIGURED;
        end else if (load_fail) begin
          cnt_d = '0;
          if (retry_q < RW'(MAX_RETRIES)) begin
            retry_d = retry_q + RW'(1);
            state_d = ST_PROG;
          end else if (img_q != IMG_W'(FALLBACK_IMAGE)) begin
            img_d   = IMG_W'(FALLBACK_IMAGE);
            retry_d = RW'(MAX_RETRIES);
            state_d = ST_PROG;
          end else begin
            state_d = ST_FAILED;
            err_d   = 1'b1;
          end
        end
      end
      ST_CONFIGURED: begin
        if (done_prev_q && !FPGA_DONE) begin
          state_d = ST_WAIT_INIT;
          cnt_d   = '0;
        end
      end
      ST_FAILED: begin
        state_d = ST_FAILED;
      end
      default: begin
        state_d = ST_CLK_MR;
        cnt_d   = '0;
      end
    endcase

    // A button press restarts configuration from any settled or active state except clock reset.
    if (btn_press && state_q != ST_CLK_MR) begin
      state_d = ST_PROG;
      cnt_d   = '0;
      img_d   = sel_img;
      retry_d = '0;
      err_d   = 1'b0;
    end else if ((state_q == ST_CONFIGURED || state_q == ST_FAILED) && ICS_FSEL_REQ != fsel_q) begin
      fsel_d  = ICS_FSEL_REQ;
      state_d = ST_CLK_MR;
      cnt_d   = '0;
    end
  end

  // Sequencer state registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      state_q     <= ST_CLK_MR;
      cnt_q       <= '0;
      retry_q     <= '0;
      img_q       <= '0;
      fsel_q      <= ICS_FSEL_DEFAULT;
      err_q       <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      img_q       <= img_d;
      fsel_q      <= fsel_d;
      err_q       <= err_d;
      done_prev_q <= FPGA_DONE;
    end
  end

  assign ce_en = (state_q == ST_PROG) || (state_q == ST_WAIT_INIT) || (state_q == ST_LOAD);

  // Only the flash holding the active image is enabled, and only while a load is in progress.
  always_comb begin
    FLASH_CE_B = '1;
    if (ce_en) FLASH_CE_B[img_q[IMG_W-1 -: FLASH_W]] = 1'b0;
  end

  assign PROG_B           = (state_q != ST_PROG);
  assign FLASH_CF_B       = PROG_B;
  assign FLASH_SEL        = img_q[REV_W-1:0];
  assign FLASH_OE_RESET_B = INIT_B;
  assign BUSY_TO_FLASH_B  = FPGA_BUSY_B;
  assign FPGA_CS_B        = 1'b0;
  assign FPGA_RDWR_B      = 1'b0;
  assign ICS_FSEL         = fsel_q;
  assign ICS_MR           = (state_q == ST_CLK_MR);
  assign ICS_OEA          = (state_q != ST_CLK_MR);
  assign CFG_STATE        = state_q;
  assign CFG_ERROR        = err_q;
  assign ACTIVE_IMAGE     = img_q;

endmodule
